// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between two requesters, A and B.
//
// With MEM_ARB_INIT_EN defined, the block first clears addresses 0..RAM_DEPTH-1.
// It writes one word per cycle and does not grant requests during this sweep.
// It then enters the serving state. Without the macro, it serves requests from
// the first cycle after reset.
// Serving grants at most one request per cycle, and grants always go to the
// requester that is asking. When both ask, the requester holding priority wins.
// Priority then passes to the other requester.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   a_*/b_* valid/ready        request handshake per requester
//   a_*/b_* we/addr/wdata      request payload (we: 1 = write, 0 = read)
//   a_rvalid/b_rvalid, rdata   read response, one cycle after the read grant
//   mem_addr/mem_write_data/
//   mem_write_enable           RAM control, combinational from the grant
//   mem_read_data              RAM registered read output
//   init_done                  high while serving requests
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  init_done
);

  if (RAM_DEPTH == 0 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("RAM_DEPTH must lie in 1 .. 2**ADDR_WIDTH");
  end

  logic                  in_init;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef MEM_ARB_INIT_EN
  typedef enum logic {StInit, StServe} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = StServe;
        cnt_d   = '0;
      end
    end
  end

  assign in_init   = (state_q == StInit);
  assign init_addr = cnt_q;
`else
  assign in_init   = 1'b0;
  assign init_addr = '0;
`endif

  logic prio_b_q;  // 0: A holds priority, 1: B holds priority
  logic a_rvalid_q, b_rvalid_q;

  // Grant and RAM drive. Reset blanks every output combinationally.
  // This also suppresses a read response that is in flight when reset rises.
  always_comb begin
    a_ready          = 1'b0;
    b_ready          = 1'b0;
    init_done        = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    if (!reset) begin
      if (in_init) begin
        mem_addr         = init_addr;
        mem_write_enable = 1'b1;
      end else begin
        init_done = 1'b1;
        if (a_valid && (!b_valid || !prio_b_q)) begin
          a_ready = 1'b1;
        end else if (b_valid) begin
          b_ready = 1'b1;
        end
        if (a_ready) begin
          mem_addr         = a_addr;
          mem_write_data   = a_wdata;
          mem_write_enable = a_we;
        end else if (b_ready) begin
          mem_addr         = b_addr;
          mem_write_data   = b_wdata;
          mem_write_enable = b_we;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_b_q   <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      if (a_ready) begin
        prio_b_q <= 1'b1;
      end else if (b_ready) begin
        prio_b_q <= 1'b0;
      end
      a_rvalid_q <= a_ready && !a_we;
      b_rvalid_q <= b_ready && !b_we;
    end
  end

  assign a_rvalid = a_rvalid_q && !reset;
  assign b_rvalid = b_rvalid_q && !reset;
  assign rdata    = mem_read_data;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: memory word width in bits; SHALL size all data ports.
REQ-002 Parameter ADDR_WIDTH, default 10: memory address width; SHALL size all address ports.
REQ-003 Parameter RAM_DEPTH, default 1 << ADDR_WIDTH: number of words swept by the init sequencer.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-006 Ports a_valid / b_valid, input, 1: requester A/B presents a request.
REQ-007 Ports a_ready / b_ready, output, 1: request accepted this cycle when valid && ready.
REQ-008 Ports a_we / b_we, input, 1: 1 = write, 0 = read.
REQ-009 Ports a_addr / b_addr, input, ADDR_WIDTH: request address.
REQ-010 Ports a_wdata / b_wdata, input, DATA_WIDTH: write data.
REQ-011 Ports a_rvalid / b_rvalid, output, 1: read data valid for A/B.
REQ-012 Port rdata, output, DATA_WIDTH: read data shared by both requesters; qualified by a_rvalid/b_rvalid.
REQ-013 Ports mem_addr (ADDR_WIDTH), mem_write_data (DATA_WIDTH), mem_write_enable (1), output: drive the single-port RAM.
REQ-014 Port mem_read_data, input, DATA_WIDTH: RAM registered read output, valid one cycle after a non-write access.
REQ-015 Port init_done, output, 1: high once the block is serving requests.

Function
REQ-016 States SHALL be INIT and SERVE; INIT -> SERVE after the write to address RAM_DEPTH-1; SERVE has no exit except reset.
REQ-017 INIT: a counter SHALL run from 0 to RAM_DEPTH-1, one per cycle, driving mem_addr = counter, mem_write_data = 0, mem_write_enable = 1.
REQ-018 INIT: a_ready = b_ready = 0 and init_done = 0; INIT SHALL last exactly RAM_DEPTH cycles.
REQ-019 SERVE: init_done = 1; at most one request is granted per cycle.
REQ-020 Only one valid: that requester SHALL be granted (ready = 1) in the same cycle.
REQ-021 Both valid: the requester holding priority SHALL be granted; the other SHALL see ready = 0.
REQ-022 Priority SHALL reset to A; after any grant, priority passes to the requester not granted.
REQ-023 Granted cycle: mem_addr = granted addr, mem_write_data = granted wdata, mem_write_enable = granted we (combinational).
REQ-024 No grant in SERVE: mem_write_enable = 0, mem_addr = 0, mem_write_data = 0.
REQ-025 Accepted read: the matching rvalid SHALL pulse high for exactly the next cycle, with rdata = mem_read_data.
REQ-026 Writes SHALL produce no rvalid pulse.
REQ-027 Back-to-back reads (any requester mix) SHALL sustain one response per cycle at 1-cycle latency.
REQ-028 A requester whose valid is held while not granted SHALL keep its request pending; nothing is dropped or reordered per requester.
REQ-029 rdata SHALL equal mem_read_data whenever either rvalid is high, and is don't-care otherwise.

Reset
REQ-030 reset high SHALL force: state = INIT (or SERVE when REQ-033 applies), counter = 0, priority = A, a_rvalid = b_rvalid = 0, a_ready = b_ready = 0, init_done = 0.
REQ-031 Reset asserted mid-INIT SHALL restart the sweep at address 0; reset mid-SERVE SHALL cancel any pending rvalid.

Configuration
REQ-032 Macro MEM_ARB_INIT_EN defined: INIT sweep per REQ-016..018 is compiled in.
REQ-033 MEM_ARB_INIT_EN undefined: no INIT state or counter; the block enters SERVE on the first cycle after reset deasserts, with init_done = 1 from that cycle.

Verification
REQ-034 INIT sweep (ADDR_WIDTH = 4, RAM_DEPTH = 16): release reset -> 16 consecutive writes of 0 to addresses 0..15, then init_done = 1 in cycle 17.
REQ-035 Single requester: A writes 0x5A at 0x003, then reads 0x003 -> a_rvalid high one cycle after the read grant, rdata = 0x5A; b_rvalid stays 0.
REQ-036 Contention: A and B both valid reads for 4 cycles -> grants A, B, A, B; rvalids alternate a, b, a, b, each 1 cycle after its grant.
REQ-037 Write/read collision: A writes 0xC3 at 0x010 while B reads 0x010 in the same cycle, priority = A -> A granted first; B granted next cycle and receives 0xC3.
REQ-038 Reset at INIT address 7 -> the sweep restarts at address 0; reset with a read in flight -> no rvalid pulse.
REQ-039 Build without MEM_ARB_INIT_EN -> a_ready = 1 on the first cycle after reset release with a_valid = 1; no mem_write_enable pulses occur without requests.
